// File: rtl/aes_key_schedule_pkg.sv
// Shared encodings, lookup constants and GF(2^8) helpers for the AES key schedule.
package aes_key_schedule_pkg;

  typedef enum logic [1:0] {
    KEY_LEN_NONE = 2'b00,
    KEY_LEN_128  = 2'b01,
    KEY_LEN_192  = 2'b10,
    KEY_LEN_256  = 2'b11
  } key_len_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EXPAND = 2'b01,
    S_READY  = 2'b10
  } ks_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Key length in 32-bit words.
  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      KEY_LEN_128: return 4'd4;
      KEY_LEN_192: return 4'd6;
      KEY_LEN_256: return 4'd8;
      default:     return 4'd0;
    endcase
  endfunction

  // Number of rounds.
  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      KEY_LEN_128: return 4'd10;
      KEY_LEN_192: return 4'd12;
      KEY_LEN_256: return 4'd14;
      default:     return 4'd0;
    endcase
  endfunction

  // Total expanded words.
  function automatic logic [5:0] words_of(input logic [1:0] len);
    case (len)
      KEY_LEN_128: return 6'd44;
      KEY_LEN_192: return 6'd52;
      KEY_LEN_256: return 6'd60;
      default:     return 6'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] shifted;
    acc = 8'h00;
    shifted = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ shifted;
      shifted = xtime(shifted);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Host key-load and round-key read bus of the AES key schedule.
interface aes_key_schedule_if;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         key_load;
  logic         busy;
  logic         keys_ready;
  logic [3:0]   subkey_addr;
  logic [127:0] subkey;
  logic         subkey_valid;

  modport master (
    output key_in, key_len, key_load, subkey_addr,
    input  busy, keys_ready, subkey, subkey_valid
  );

  modport slave (
    input  key_in, key_len, key_load, subkey_addr,
    output busy, keys_ready, subkey, subkey_valid
  );
endinterface

// File: rtl/aes_key_schedule_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_key_schedule_sbox
  import aes_key_schedule_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);

  logic [7:0] power;
  logic [7:0] inv;

  // x^254 = x^-1, built as the product x^2 * x^4 * ... * x^128 (0 maps to 0).
  always_comb begin
    power = value;
    inv   = 8'h01;
    for (int k = 1; k < 8; k++) begin
      power = gf_mul(power, power);
      inv   = gf_mul(inv, power);
    end
  end

  assign result = inv
                ^ {inv[6:0], inv[7]}
                ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]}
                ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// FIPS-197 key expansion, one word per cycle, with a combinational round-key read port.
// Build option AES_KS_ZEROIZE_EN: zero the word store on reset/load and mask invalid reads.
module aes_key_schedule
  import aes_key_schedule_pkg::*;
#(
  parameter int MAX_WORDS = 60
) (
  input  logic clk,
  input  logic reset,
  aes_key_schedule_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);

  ks_state_t        state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [2:0]       mod_reg;
  logic [7:0]       rcon_reg;
  logic [3:0]       nk_reg;
  logic [3:0]       nr_reg;
  logic [IDX_W-1:0] last_reg;
  logic             busy_reg;
  logic             ready_reg;

  logic [31:0]      w_mem [MAX_WORDS];
  logic             load_accept;
  logic             expand_we;
  logic [3:0]       nk_load;
  logic [IDX_W-1:0] prev_idx;
  logic [IDX_W-1:0] back_idx;
  logic [31:0]      w_prev;
  logic [31:0]      w_back;
  logic [31:0]      sub_in;
  logic [31:0]      sub_out;
  logic [31:0]      temp;
  logic [31:0]      next_word;
  logic [IDX_W-1:0] base_idx;
  logic [127:0]     subkey_raw;
  logic             subkey_valid;

  assign nk_load     = nk_of(bus.key_len);
  assign load_accept = !reset && bus.key_load && (state_reg != S_EXPAND)
                     && (bus.key_len != KEY_LEN_NONE);
  assign expand_we   = !reset && (state_reg == S_EXPAND);

  // Word store: one register per word so a load can write up to eight words at once.
  generate
    for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_word
      logic [31:0] word_reg;
      logic [31:0] key_word;
      logic        key_slot;
      if (gi < 8) begin : g_key
        assign key_word = bus.key_in[255-32*gi -: 32];
        assign key_slot = (IDX_W'(gi) < IDX_W'(nk_load));
      end else begin : g_gen
        assign key_word = 32'h0;
        assign key_slot = 1'b0;
      end
      always_ff @(posedge clk) begin
        if (load_accept && key_slot) begin
          word_reg <= key_word;
        end
`ifdef AES_KS_ZEROIZE_EN
        else if (reset || load_accept) begin
          word_reg <= 32'h0;
        end
`endif
        else if (expand_we && (idx_reg == IDX_W'(gi))) begin
          word_reg <= next_word;
        end
      end
      assign w_mem[gi] = word_reg;
    end
  endgenerate

  assign prev_idx = idx_reg - IDX_W'(1);
  assign back_idx = idx_reg - IDX_W'(nk_reg);
  assign w_prev   = w_mem[prev_idx];
  assign w_back   = w_mem[back_idx];

  // RotWord only applies on the i mod Nk == 0 step; the AES-256 mid-step uses SubWord alone.
  assign sub_in = (mod_reg == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_key_schedule_sbox u_sbox (
        .value  (sub_in[8*gi +: 8]),
        .result (sub_out[8*gi +: 8])
      );
    end
  endgenerate

  always_comb begin
    temp = w_prev;
    if (mod_reg == 3'd0) begin
      temp = sub_out ^ {rcon_reg, 24'h000000};
    end else if ((nk_reg == 4'd8) && (mod_reg == 3'd4)) begin
      temp = sub_out;
    end
    next_word = w_back ^ temp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      mod_reg   <= 3'd0;
      rcon_reg  <= RCON_INIT;
      nk_reg    <= 4'd0;
      nr_reg    <= 4'd0;
      last_reg  <= '0;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_READY: begin
          if (load_accept) begin
            nk_reg    <= nk_load;
            nr_reg    <= nr_of(bus.key_len);
            last_reg  <= IDX_W'(words_of(bus.key_len) - 6'd1);
            idx_reg   <= IDX_W'(nk_load);
            mod_reg   <= 3'd0;
            rcon_reg  <= RCON_INIT;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          idx_reg <= idx_reg + IDX_W'(1);
          mod_reg <= ({1'b0, mod_reg} == (nk_reg - 4'd1)) ? 3'd0 : mod_reg + 3'd1;
          if (mod_reg == 3'd0) begin
            rcon_reg <= xtime(rcon_reg);
          end
          if (idx_reg == last_reg) begin
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= S_READY;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Round-key read: four consecutive words, addresses past the store return zero.
  assign base_idx = IDX_W'({bus.subkey_addr, 2'b00});

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_read
      logic [IDX_W-1:0] rd_idx;
      assign rd_idx = base_idx + IDX_W'(gi);
      assign subkey_raw[127-32*gi -: 32] = (rd_idx <= LAST_IDX) ? w_mem[rd_idx] : 32'h0;
    end
  endgenerate

  assign subkey_valid     = ready_reg && (bus.subkey_addr <= nr_reg);
  assign bus.subkey_valid = subkey_valid;
  assign bus.busy         = busy_reg;
  assign bus.keys_ready   = ready_reg;

`ifdef AES_KS_ZEROIZE_EN
  assign bus.subkey = subkey_valid ? subkey_raw : 128'h0;
`else
  assign bus.subkey = subkey_raw;
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed and random checks of aes_key_schedule against a table-driven FIPS-197 model.
module tb_aes_key_schedule;

  logic clk = 1'b0;
  logic reset;

  aes_key_schedule_if bus ();

  aes_key_schedule #(.MAX_WORDS(60)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  sbox_tbl [256];
  logic [7:0]  rcon_tbl [10];
  logic [31:0] m_w [60];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // S-box table from the generator-3 walk over GF(2^8)*, independent of the RTL's inversion.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tbl[0] = 8'h63;
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    int total;
    total = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) m_w[i] = key[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = m_w[i-1];
      if (i % nk == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon_tbl[i/nk - 1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subword(t);
      m_w[i] = m_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int a);
    return {m_w[4*a], m_w[4*a+1], m_w[4*a+2], m_w[4*a+3]};
  endfunction

  task automatic do_load(input logic [255:0] key, input logic [1:0] len);
    tick();
    bus.key_in   = key;
    bus.key_len  = len;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
  endtask

  task automatic wait_ready(input int start, output int n);
    n = start;
    while (bus.keys_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic read_key(input int a, output logic [127:0] sk, output logic v);
    bus.subkey_addr = 4'(a);
    #1;
    sk = bus.subkey;
    v  = bus.subkey_valid;
  endtask

  // Decrypt-order walk, one address per clock, from Nr down to 0.
  task automatic sweep(input int nr, input string tag);
    for (int a = nr; a >= 0; a--) begin
      bus.subkey_addr = 4'(a);
      tick();
      check($sformatf("%s_valid_a%0d", tag, a), bus.subkey_valid, 1'b1);
      check($sformatf("%s_key_a%0d", tag, a), bus.subkey, model_rk(a));
    end
  endtask

  initial begin
    logic [255:0] k128, k192, k256, kr;
    logic [127:0] sk;
    logic         v;
    int           n;
    int           nk;
    logic [1:0]   len;

    build_sbox();
    rcon_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    reset           = 1'b1;
    bus.key_in      = '0;
    bus.key_len     = 2'b00;
    bus.key_load    = 1'b0;
    bus.subkey_addr = 4'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.keys_ready, 1'b0);
    check("rst_valid", bus.subkey_valid, 1'b0);
`ifdef AES_KS_ZEROIZE_EN
    for (int a = 0; a < 16; a++) begin
      read_key(a, sk, v);
      check($sformatf("zero_rst_a%0d", a), sk, 128'h0);
    end
`endif

    // Invalid key length in IDLE is ignored.
    do_load(k256, 2'b00);
    check("len0_idle_busy", bus.busy, 1'b0);
    check("len0_idle_ready", bus.keys_ready, 1'b0);

    // AES-128 vector with a second key_load injected while busy.
    model_expand(k128, 4);
    do_load(k128, 2'b01);
    check("load128_busy", bus.busy, 1'b1);
    n = 1;
    repeat (4) begin tick(); n++; end
    bus.key_in   = k256;
    bus.key_len  = 2'b11;
    bus.key_load = 1'b1;
    tick();
    n++;
    bus.key_load = 1'b0;
    wait_ready(n, n);
    check("lat128", n, 41);
    read_key(1, sk, v);
    check("a128_w4", sk[127:96], 32'ha0fafe17);
    read_key(10, sk, v);
    check("a128_a10", sk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_key(11, sk, v);
    check("a128_a11_valid", v, 1'b0);
`ifdef AES_KS_ZEROIZE_EN
    check("a128_a11_zero", sk, 128'h0);
`endif
    sweep(10, "sw128");

    // Invalid key length in READY leaves the schedule intact.
    do_load(k256, 2'b00);
    check("len0_ready_ready", bus.keys_ready, 1'b1);
    check("len0_ready_busy", bus.busy, 1'b0);
    read_key(10, sk, v);
    check("len0_ready_a10", sk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-192 reload from READY.
    model_expand(k192, 6);
    bus.subkey_addr = 4'd0;
    do_load(k192, 2'b10);
    check("reload_ready_drop", bus.keys_ready, 1'b0);
    check("reload_valid_drop", bus.subkey_valid, 1'b0);
    wait_ready(1, n);
    check("lat192", n, 47);
    read_key(1, sk, v);
    check("a192_w6", sk[63:32], 32'hfe0c91f7);
    read_key(12, sk, v);
    check("a192_a12", sk, 128'he98ba06f448c773c8ecc720401002202);
    read_key(13, sk, v);
    check("a192_a13_valid", v, 1'b0);
    sweep(12, "sw192");

    // AES-256.
    model_expand(k256, 8);
    do_load(k256, 2'b11);
    wait_ready(1, n);
    check("lat256", n, 53);
    read_key(2, sk, v);
    check("a256_w8", sk[127:96], 32'h9ba35411);
    read_key(14, sk, v);
    check("a256_a14", sk, 128'hfe4890d1e6188d0b046df344706c631e);
    read_key(15, sk, v);
    check("a256_a15_valid", v, 1'b0);
    sweep(14, "sw256");

    // Reset during expansion.
    kr = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    do_load(kr, 2'b01);
    repeat (19) tick();
    check("abort_busy_pre", bus.busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_ready", bus.keys_ready, 1'b0);
    check("abort_valid", bus.subkey_valid, 1'b0);
    tick();
    check("abort_idle", bus.busy, 1'b0);

    model_expand(k128, 4);
    do_load(k128, 2'b01);
    wait_ready(1, n);
    check("lat128_post", n, 41);
    read_key(10, sk, v);
    check("post_a10", sk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep(10, "swpost");
`ifdef AES_KS_ZEROIZE_EN
    for (int a = 11; a < 16; a++) begin
      read_key(a, sk, v);
      check($sformatf("zero_tail_a%0d", a), sk, 128'h0);
    end
`endif

    // Random keys of random length, every address checked.
    for (int r = 0; r < 6; r++) begin
      nk  = 4 + 2 * int'($urandom_range(0, 2));
      len = (nk == 4) ? 2'b01 : (nk == 6) ? 2'b10 : 2'b11;
      kr  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      model_expand(kr, nk);
      do_load(kr, len);
      wait_ready(1, n);
      check($sformatf("rnd%0d_lat", r), n, 4 * (nk + 7) - nk + 1);
      for (int a = 0; a < 16; a++) begin
        read_key(a, sk, v);
        check($sformatf("rnd%0d_valid_a%0d", r, a), v, (a <= nk + 6));
        if (a <= nk + 6) begin
          check($sformatf("rnd%0d_key_a%0d", r, a), sk, model_rk(a));
        end
`ifdef AES_KS_ZEROIZE_EN
        else begin
          check($sformatf("rnd%0d_zero_a%0d", r, a), sk, 128'h0);
        end
`endif
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
